bcd_convert_scheduler: RTL and testbench



---
 rtl/bcd_convert_scheduler.sv | 144 ++++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one combinational binary-to-BCD converter
// among N_REQ requesters. The operand is registered and held for
// SETTLE_CYCLES so the add-3 chain can be timed as a multicycle path.
module bcd_convert_scheduler #(
  parameter int N_REQ         = 3,
  parameter int BIN_BITS      = 20,
  parameter int BCD_BITS      = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_BITS       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*BIN_BITS-1:0] bin_in,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ*BCD_BITS-1:0] bcd_out,
  output logic                      busy,
  output logic [ID_BITS-1:0]        grant_id
);

  localparam int DIGITS       = BCD_BITS / 4;
  // Enough digits to hold any BIN_BITS value (31/100 over-estimates log10(2))
  localparam int FULL_DIG_RAW = (BIN_BITS * 31) / 100 + 1;
  localparam int FULL_DIG     = (FULL_DIG_RAW > DIGITS) ? FULL_DIG_RAW : DIGITS;
  localparam int CNT_BITS     = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t              state_reg;
  logic [BIN_BITS-1:0] operand_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic [ID_BITS-1:0]  rr_ptr_reg;
  logic [ID_BITS-1:0]  grant_id_reg;
  logic                busy_reg;
  logic [N_REQ-1:0]    ack_reg;
  logic [BCD_BITS-1:0] bcd_reg [N_REQ];
  logic [BIN_BITS-1:0] bin_arr [N_REQ];

  logic [N_REQ-1:0]    eff;
  logic                grant_valid;
  logic [ID_BITS-1:0]  grant_sel;
  logic [BCD_BITS-1:0] conv_result;

  // Double-dabble over the full digit range; the low DIGITS digits are the
  // result modulo 10^DIGITS, so truncation falls out of the slice.
  function automatic logic [BCD_BITS-1:0] bin2bcd(input logic [BIN_BITS-1:0] b);
    logic [4*FULL_DIG-1:0] acc;
    acc = '0;
    for (int i = BIN_BITS - 1; i >= 0; i--) begin
      for (int d = 0; d < FULL_DIG; d++) begin
        if (acc[4*d +: 4] >= 4'd5) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*FULL_DIG-2:0], b[i]};
    end
    return acc[BCD_BITS-1:0];
  endfunction

  // The converter only ever sees the held operand register
  assign conv_result = bin2bcd(operand_reg);

  // A requester whose ack is high this cycle is not eligible again yet
  assign eff = req & ~ack_reg;

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_sel   = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_valid && (j == idx) && eff[j]) begin
          grant_valid = 1'b1;
          grant_sel   = ID_BITS'(j);
        end
      end
    end
  end

  // Scheduler FSM with registered busy/grant/ack outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      operand_reg  <= '0;
      cnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      busy_reg     <= 1'b0;
      ack_reg      <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            operand_reg  <= bin_arr[grant_sel];
            grant_id_reg <= grant_sel;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_BITS'(SETTLE_CYCLES - 1)) state_reg <= DONE;
        end
        DONE: begin
          ack_reg[grant_id_reg] <= 1'b1;
          if (int'(grant_id_reg) == N_REQ - 1) rr_ptr_reg <= '0;
          else rr_ptr_reg <= grant_id_reg + 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign bin_arr[gi] = bin_in[gi*BIN_BITS +: BIN_BITS];

      // Result slice changes only when this requester's conversion completes
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          bcd_reg[gi] <= '0;
        end else if (state_reg == DONE && grant_id_reg == ID_BITS'(gi)) begin
          bcd_reg[gi] <= conv_result;
        end
      end

      assign bcd_out[gi*BCD_BITS +: BCD_BITS] = bcd_reg[gi];
    end
  endgenerate

  assign ack      = ack_reg;
  assign busy     = busy_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench for bcd_convert_scheduler: directed table, hand
// sequences for multi-cycle corners, and randomized traffic vs a
// transaction-level reference model.
module tb_bcd_convert_scheduler;

  localparam int N  = 3;
  localparam int BB = 20;
  localparam int CB = 24;
  localparam int SC = 2;
  localparam int IB = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*BB-1:0] bin_in = '0;
  logic [N-1:0]    ack;
  logic [N*CB-1:0] bcd_out;
  logic            busy;
  logic [IB-1:0]   grant_id;

  bcd_convert_scheduler #(
    .N_REQ(N), .BIN_BITS(BB), .BCD_BITS(CB), .SETTLE_CYCLES(SC), .ID_BITS(IB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
    .ack(ack), .bcd_out(bcd_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          rq;
    int unsigned opnd;
    logic [23:0] exp_bcd;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference conversion from plain decimal arithmetic, 6 digits kept
  function automatic logic [23:0] bcd_ref(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] slice_of(input int i);
    return bcd_out[i*CB +: CB];
  endfunction

  task automatic set_op(input int i, input int unsigned v);
    bin_in[i*BB +: BB] = v[BB-1:0];
  endtask

  function automatic int ack_index(input logic [N-1:0] a);
    int r;
    r = -1;
    for (int j = 0; j < N; j++) if (a[j]) r = j;
    return r;
  endfunction

  // Round-robin rule: first eligible requester at or after ptr, wrapping
  function automatic int rr_pick(input int ptr, input logic [N-1:0] e);
    for (int k = 0; k < N; k++) begin
      if (e[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_bcd_out", bcd_out, 0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_ack(input int lim, output logic [N-1:0] a);
    a = '0;
    for (int k = 0; k < lim; k++) begin
      tick();
      if (ack != '0) begin
        a = ack;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL ack_timeout: no ack within %0d cycles (cycle %0d)", lim, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]    a;
    logic [N-1:0]    onehot;
    logic [N*CB-1:0] snap;
    int              start;

    vecs[0] = '{0, 32'd12345,   24'h012345};
    vecs[1] = '{1, 32'd0,       24'h000000};
    vecs[2] = '{2, 32'd999999,  24'h999999};
    vecs[3] = '{0, 32'd1000000, 24'h000000};
    vecs[4] = '{1, 32'd1048575, 24'h048575};
    vecs[5] = '{2, 32'd7,       24'h000007};
    vecs[6] = '{0, 32'd90909,   24'h090909};

    // ---------------- directed table ----------------
    do_reset();
    for (int v = 0; v < 7; v++) begin
      snap   = bcd_out;
      start  = cyc;
      onehot = N'(1 << vecs[v].rq);
      req    = onehot;
      set_op(vecs[v].rq, vecs[v].opnd);
      tick();
      chk("vec_busy", busy, 1);
      wait_ack(10, a);
      chk("vec_ack", a, onehot);
      chk("vec_latency", cyc - start, SC + 2);
      chk("vec_bcd", slice_of(vecs[v].rq), vecs[v].exp_bcd);
      for (int j = 0; j < N; j++) begin
        if (j != vecs[v].rq) chk("vec_other_slice", slice_of(j), snap[j*CB +: CB]);
      end
      $display("[TB] vec %0d: req %0d operand %0d -> bcd %06h", v, vecs[v].rq, vecs[v].opnd, slice_of(vecs[v].rq));
      req = '0;
    end

    // ---------------- all three together ----------------
    begin
      logic [N-1:0] exp_ack [3];
      logic [23:0]  exp_res [3];
      int k;
      exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100;
      exp_res[0] = 24'h000007; exp_res[1] = 24'h000099; exp_res[2] = 24'h048575;
      do_reset();
      set_op(0, 7); set_op(1, 99); set_op(2, 1048575);
      req = 3'b111;
      k = 0;
      for (int t = 0; t < 16 && k < 3; t++) begin
        tick();
        if (ack != '0) begin
          chk("all3_ack", ack, exp_ack[k]);
          chk("all3_cycle", cyc, 4 * (k + 1));
          chk("all3_bcd", slice_of(ack_index(ack)), exp_res[k]);
          $display("[TB] all3: ack %b at cycle %0d", ack, cyc);
          req = req & ~ack;
          k++;
        end
      end
      chk("all3_count", k, 3);
      req = '0;
    end

    // ---------------- round-robin fairness ----------------
    begin
      int count;
      do_reset();
      set_op(0, 11); set_op(1, 22);
      req = 3'b011;
      count = 0;
      for (int t = 0; t < 40 && count < 6; t++) begin
        tick();
        if (ack != '0) begin
          chk("rr_order", ack_index(ack), count % 2);
          $display("[TB] rr: conversion %0d served requester %0d", count, ack_index(ack));
          count++;
        end
      end
      req = '0;
      chk("rr_count", count, 6);
    end

    // ---------------- operand stability ----------------
    do_reset();
    set_op(1, 500);
    req = 3'b010;
    tick();
    set_op(1, 777);
    wait_ack(10, a);
    chk("stable_ack", a, 3'b010);
    chk("stable_bcd", slice_of(1), 24'h000500);
    $display("[TB] stability: bcd[1] = %06h", slice_of(1));
    req = '0;

    // ---------------- early drop ----------------
    begin
      int busy_seen;
      do_reset();
      set_op(2, 314159);
      req = 3'b100;
      tick();
      req = '0;
      wait_ack(10, a);
      chk("drop_ack", a, 3'b100);
      chk("drop_cycle", cyc, 4);
      chk("drop_bcd", slice_of(2), 24'h314159);
      busy_seen = 0;
      for (int t = 0; t < 8; t++) begin
        tick();
        if (busy) busy_seen++;
      end
      chk("drop_no_regrant", busy_seen, 0);
      $display("[TB] early drop: ack seen, busy cycles after = %0d", busy_seen);
    end

    // ---------------- held through ack: exactly one regrant ----------------
    begin
      int n_grant, n_ack;
      logic prev_busy;
      do_reset();
      set_op(2, 271828);
      req = 3'b100;
      wait_ack(10, a);
      chk("hold_first_cycle", cyc, 4);
      n_grant = 0; n_ack = 0; prev_busy = 1'b0;
      for (int t = 0; t < 16; t++) begin
        tick();
        if (busy && !prev_busy) n_grant++;
        if (ack[2]) begin
          n_ack++;
          chk("hold_second_cycle", cyc, 9);
        end
        prev_busy = busy;
        if (cyc == 6) req = '0;
      end
      chk("hold_grants", n_grant, 1);
      chk("hold_acks", n_ack, 1);
      $display("[TB] held req: %0d regrants, %0d acks", n_grant, n_ack);
    end

    // ---------------- reset mid-conversion ----------------
    set_op(0, 123456);
    req = 3'b001;
    tick();
    tick();
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_bcd", bcd_out, 0);
    chk("midrst_grant", grant_id, 0);
    tick();
    chk("midrst_ack2", ack, 0);
    rst_n = 1'b1;
    cyc = 0;
    set_op(0, 42);
    req = 3'b001;
    wait_ack(10, a);
    chk("midrst_after_ack", a, 3'b001);
    chk("midrst_after_cycle", cyc, 4);
    chk("midrst_after_bcd", slice_of(0), 24'h000042);
    $display("[TB] mid reset: follow-up bcd[0] = %06h at cycle %0d", slice_of(0), cyc);
    req = '0;

    // ---------------- randomized traffic vs model ----------------
    begin
      int unsigned     op [N];
      int              waited [N];
      logic [N*CB-1:0] shadow;
      int              ptr, pred_mode, pred_id, rise_cyc, id, n_conv;
      logic [N-1:0]    e;
      do_reset();
      ptr = 0; pred_mode = 1; pred_id = -1; rise_cyc = 0; n_conv = 0;
      shadow = '0;
      for (int j = 0; j < N; j++) begin op[j] = 0; waited[j] = 0; end
      for (int t = 0; t < 2000; t++) begin
        tick();
        if (pred_mode == 2) begin
          chk("rnd_grant_busy", busy, 1);
          chk("rnd_grant_id", grant_id, pred_id);
          rise_cyc = cyc;
        end else if (pred_mode == 1) begin
          chk("rnd_idle", busy, 0);
        end
        chk("rnd_ack_onehot", ($countones(ack) <= 1), 1);
        if (ack != '0) begin
          id = ack_index(ack);
          chk("rnd_ack_id", id, grant_id);
          chk("rnd_latency", cyc - rise_cyc, SC + 1);
          chk("rnd_waited", (waited[id] <= N - 1), 1);
          shadow[id*CB +: CB] = bcd_ref(op[id]);
          chk("rnd_bcd_out", bcd_out, shadow);
          ptr = (id + 1) % N;
          for (int j = 0; j < N; j++) if (j != id && req[j]) waited[j]++;
          req[id] = 1'b0;
          n_conv++;
        end else begin
          chk("rnd_bcd_hold", bcd_out, shadow);
        end
        for (int j = 0; j < N; j++) begin
          if (!req[j]) begin
            if ($urandom_range(0, 3) == 0) begin
              case ($urandom_range(0, 3))
                0: op[j] = $urandom_range(999990, 1000010);
                1: op[j] = $urandom_range(0, 99);
                default: op[j] = $urandom & 32'hFFFFF;
              endcase
              set_op(j, op[j]);
              req[j] = 1'b1;
              waited[j] = 0;
            end else begin
              set_op(j, $urandom);
            end
          end
        end
        if (!busy) begin
          e = req & ~ack;
          pred_id = rr_pick(ptr, e);
          pred_mode = (pred_id >= 0) ? 2 : 1;
        end else begin
          pred_mode = 0;
        end
      end
      req = '0;
      $display("[TB] random: %0d conversions checked", n_conv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
